// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared core constants and helpers for the ARM pipeline
package arm_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_INSTR        = 32'd0;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'd0;
    localparam logic [WORD_W-1:0] DEFAULT_PC_STEP  = 32'd4;

    // Instruction fetches are word-granular; low address bits are ignored.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return addr & ~32'd3;
    endfunction
endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bundle: control, instruction memory and IF/ID outputs
interface if_stage_if;
    import arm_pkg::*;
    logic              freeze;
    logic              branch_taken;
    logic [WORD_W-1:0] branch_address;
    logic [WORD_W-1:0] PC_in;
    logic [WORD_W-1:0] instruction;
    logic [WORD_W-1:0] if_pc;
    logic [WORD_W-1:0] if_instruction;
    logic              if_valid;
    logic [WORD_W-1:0] fetch_count;

    modport master (
        output freeze, branch_taken, branch_address, instruction,
        input  PC_in, if_pc, if_instruction, if_valid, fetch_count
    );

    modport slave (
        input  freeze, branch_taken, branch_address, instruction,
        output PC_in, if_pc, if_instruction, if_valid, fetch_count
    );
endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline register with flush, freeze and valid tracking
module if_id_reg
    import arm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic [WORD_W-1:0] pc_d,
    input  logic [WORD_W-1:0] instr_d,
    output logic [WORD_W-1:0] pc_q,
    output logic [WORD_W-1:0] instr_q,
    output logic              valid_q
);
    // Flush beats freeze so a redirect never leaves a stale instruction behind.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (!freeze) begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= 1'b1;
        end
    end
endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC register, next-PC mux, IF/ID register, fetch counter
module if_stage
    import arm_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [WORD_W-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic         clk,
    input  logic         rst,
    if_stage_if.slave    bus
);
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus;
    logic [WORD_W-1:0] pc_next;
    logic              capture;
    logic [WORD_W-1:0] count;

    assign pc_plus   = pc + PC_STEP;
    assign bus.PC_in = pc;
    assign capture   = !bus.branch_taken && !bus.freeze;

    always_comb begin
        pc_next = pc_plus;
        if (bus.branch_taken) begin
            pc_next = align_word(bus.branch_address);
        end else if (bus.freeze) begin
            pc_next = pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            count <= '0;
        end else begin
            pc <= pc_next;
            if (capture) begin
                count <= count + 32'd1;
            end
        end
    end

    assign bus.fetch_count = count;

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.branch_taken),
        .freeze  (bus.freeze),
        .pc_d    (pc_plus),
        .instr_d (bus.instruction),
        .pc_q    (bus.if_pc),
        .instr_q (bus.if_instruction),
        .valid_q (bus.if_valid)
    );
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage with directed fetch/stall/branch vectors
module tb_if_stage;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] ipc;
        logic        v;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    if_stage_if bus ();

    if_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory model: combinational read
    assign bus.instruction = 32'hA000_0000 | bus.PC_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("PC_in", bus.PC_in, e.pc);
                check("if_instruction", bus.if_instruction, e.ins);
                check("if_pc", bus.if_pc, e.ipc);
                check("if_valid", {31'd0, bus.if_valid}, {31'd0, e.v});
                check("fetch_count", bus.fetch_count, e.cnt);
            end
        end
    end

    task automatic step(input logic r, input logic f, input logic b, input logic [31:0] addr,
                        input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] ipc,
                        input logic v, input logic [31:0] cnt);
        exp_t e;
        rst                = r;
        bus.freeze         = f;
        bus.branch_taken   = b;
        bus.branch_address = addr;
        e.pc = pc; e.ins = ins; e.ipc = ipc; e.v = v; e.cnt = cnt;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int wait_cycles;
        rst = 1'b1;
        bus.freeze = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_address = 32'd0;
        //    rst  frz  br   addr           PC_in          if_instruction if_pc          v     count
        step(1'b1, 1'b0, 1'b0, 32'h0,        32'h0,         32'h0,         32'h0,         1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h4,         32'hA000_0000, 32'h4,         1'b1, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h8,         32'hA000_0004, 32'h8,         1'b1, 32'd2);
        step(1'b0, 1'b1, 1'b0, 32'h0,        32'h8,         32'hA000_0004, 32'h8,         1'b1, 32'd2);
        step(1'b0, 1'b1, 1'b0, 32'h0,        32'h8,         32'hA000_0004, 32'h8,         1'b1, 32'd2);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'hC,         32'hA000_0008, 32'hC,         1'b1, 32'd3);
        step(1'b0, 1'b0, 1'b1, 32'h40,       32'h40,        32'h0,         32'h0,         1'b0, 32'd3);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h44,        32'hA000_0040, 32'h44,        1'b1, 32'd4);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h48,        32'hA000_0044, 32'h48,        1'b1, 32'd5);
        step(1'b0, 1'b1, 1'b1, 32'h23,       32'h20,        32'h0,         32'h0,         1'b0, 32'd5);
        step(1'b0, 1'b1, 1'b0, 32'h0,        32'h20,        32'h0,         32'h0,         1'b0, 32'd5);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h24,        32'hA000_0020, 32'h24,        1'b1, 32'd6);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0,        32'h0,         1'b0, 32'd6);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         32'hFFFF_FFFC, 32'h0,         1'b1, 32'd7);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h4,         32'hA000_0000, 32'h4,         1'b1, 32'd8);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h8,         32'hA000_0004, 32'h8,         1'b1, 32'd9);
        step(1'b1, 1'b0, 1'b1, 32'h80,       32'h0,         32'h0,         32'h0,         1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h4,         32'hA000_0000, 32'h4,         1'b1, 32'd1);
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
